nc_reset_serializer: RTL and testbench
======================================

# nc_reset_serializer

Parallel-to-serial transmitter whose shift register takes a non-constant, input-driven value during asynchronous reset. The reset word is transmitted as the first frame after reset without any handshake. Later words are loaded through a valid/ready port. It drives a true line and a complement line, and sits at the transmit end of a serial link.

## Interface
- WIDTH, 8, frame length in bits (WIDTH >= 2).

- clk  input  1  single clock, all state on rising edge.
- rstn  input  1  reset, asynchronous, active-low; one clock domain.
- reset_word  input  WIDTH  value loaded into the shift register while rstn is low; need not be constant.
- load_valid  input  1  load_data is valid.
- load_data  input  WIDTH  next frame, MSB transmitted first.
- load_ready  output  1  word accepted on an edge where load_valid && load_ready.
- serial_out  output  1  serial data, MSB first; idle level 1.
- serial_out_n  output  1  always ~serial_out, including during reset.
- frame  output  1  high while a frame bit is on serial_out.
- done  output  1  one-cycle pulse after the last bit of each frame.

## Operation
- States: SHIFT, IDLE.
- While rstn is low, all of the following hold continuously and track reset_word changes:
  - shreg = reset_word and bitcnt = WIDTH-1.
  - State is SHIFT.
  - serial_out = reset_word[WIDTH-1], serial_out_n = ~reset_word[WIDTH-1].
  - frame = 1, done = 0, load_ready = 0.
- The value present at rstn deassertion is the first frame.
- SHIFT, each edge:
  - shreg shifts left by one.
  - bitcnt decrements.
  - serial_out = shreg[WIDTH-1].
- Last bit (bitcnt == 0):
  - load_ready = 1, combinationally.
  - On the edge, if load_valid, load load_data, set bitcnt = WIDTH-1 and stay in SHIFT (back-to-back frames, no gap).
  - Otherwise go to IDLE.
  - In both cases done = 1 for the following cycle.
- IDLE:
  - serial_out = 1, serial_out_n = 0, frame = 0, load_ready = 1.
  - On load_valid, load load_data and go to SHIFT; the MSB appears in the next cycle.
- load_ready is 0 in SHIFT except on the last bit. load_valid is ignored while load_ready = 0.
- Sender rule: load_data must stay stable while load_valid is high and the word has not been accepted.
- Reset asserted mid-frame: the frame aborts immediately and shreg reloads reset_word. The reset word is retransmitted after release.
- bitcnt is $clog2(WIDTH) bits wide and never wraps below 0; it is reloaded on accept.

## Timing
- Cycle 0 runs from rstn release to the first edge.
- Frame n occupies cycles n*WIDTH to n*WIDTH+WIDTH-1 when frames run back-to-back.
- After reset:
  - bit WIDTH-1-k of reset_word is on serial_out in cycle k.
  - done is high in cycle WIDTH.
- Accept in IDLE on edge E: the MSB is on the line from E to E+1. There is exactly 1 cycle of latency from accept to the first bit.
- Accept on the last bit: the new MSB follows the old LSB in the very next cycle.
- done is high exactly 1 cycle per frame, in the cycle after the LSB. This coincides with the new MSB when back-to-back.
- serial_out and serial_out_n are registered or derived only from registered state, so no combinational path from load_* exists.

## Structure
- Package nc_serializer_pkg holds:
  - the state enum (S_SHIFT, S_IDLE);
  - IDLE_LEVEL = 1'b1;
  - a bit-count width function.
- Sub-module nc_reset_shreg: WIDTH-bit shift register with asynchronous non-constant preload, parallel load and shift enable. It exposes its MSB and the complement of its MSB.
- The top level holds the FSM, bitcnt, the handshake logic and the done flop.

## Test plan
- WIDTH=8, reset_word=8'hA5 held through rstn release, load_valid=0:
  - serial_out reads 1,0,1,0,0,1,0,1 in cycles 0-7;
  - serial_out_n is the complement throughout;
  - done is high in cycle 8;
  - the line then idles with serial_out=1 and frame=0.
- rstn low, reset_word toggles 8'h00→8'h80→8'h00 → serial_out follows 0→1→0 asynchronously with no clock edge, and serial_out_n is inverted.
- load_valid held high with load_data=8'h3C, then 8'hC3 → frames A5, 3C, C3 run back-to-back with no idle gap, and done pulses once per frame.
- In IDLE, load_valid=1 with load_data=8'h01 → accepted on the first edge; serial_out reads 0×7 then 1; load_ready stays 0 for the next 7 cycles.
- Mid-frame (bit 3 of 8'h3C), assert rstn low with reset_word=8'hF0:
  - outputs jump to the reset values immediately;
  - after release, F0 is transmitted in full;
  - no done pulse occurs for the aborted frame.
- load_valid asserted during SHIFT (not on the last bit) with changing load_data → nothing is accepted until the last bit; the value present then is loaded.

Source files
------------

// File: rtl/nc_serializer_pkg.sv
// Shared types and constants for the reset-preloaded serial transmitter.
package nc_serializer_pkg;

    typedef enum logic {
        S_SHIFT = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Bit-counter width for a frame of w bits; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/nc_reset_shreg.sv
// Shift register with asynchronous, input-driven preload, parallel load and
// left shift. Exposes the MSB and its complement.
module nc_reset_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] preload_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    output logic             msb_o,
    output logic             msb_n_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_en_i) begin
            shreg_d = load_data_i;
        end else if (shift_en_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shreg_q <= preload_i;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // The flop only samples the preload on edges, so the live preload is
    // muxed straight through while reset is held to track it continuously.
    assign msb_o   = rstn_i ? shreg_q[WIDTH-1] : preload_i[WIDTH-1];
    assign msb_n_o = ~msb_o;

endmodule

// File: rtl/nc_reset_serializer.sv
// Parallel-to-serial transmitter: the reset word goes out as the first frame,
// later frames are loaded through a valid/ready port; true and complement lines.
module nc_reset_serializer
    import nc_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] reset_word,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_out_n,
    output logic             frame,
    output logic             done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] bitcnt_q;
    logic [CW-1:0] bitcnt_d;
    logic          done_q;
    logic          done_d;
    logic          ready;
    logic          load_en;
    logic          shift_en;
    logic          last_bit;
    logic          in_shift;
    logic          msb;
    logic          msb_n;

    assign last_bit = (bitcnt_q == '0);
    assign in_shift = (state_q == S_SHIFT);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        ready    = 1'b0;
        load_en  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            S_SHIFT: begin
                if (last_bit) begin
                    ready  = 1'b1;
                    done_d = 1'b1;
                    if (load_valid) begin
                        load_en  = 1'b1;
                        bitcnt_d = LAST_IDX;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    shift_en = 1'b1;
                    bitcnt_d = bitcnt_q - CW'(1);
                end
            end
            S_IDLE: begin
                ready = 1'b1;
                if (load_valid) begin
                    load_en  = 1'b1;
                    bitcnt_d = LAST_IDX;
                    state_d  = S_SHIFT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_SHIFT;
            bitcnt_q <= LAST_IDX;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            done_q   <= done_d;
        end
    end

    nc_reset_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .preload_i   (reset_word),
        .load_en_i   (load_en),
        .load_data_i (load_data),
        .shift_en_i  (shift_en),
        .msb_o       (msb),
        .msb_n_o     (msb_n)
    );

    // Outputs are forced to their reset meaning while rstn is low, independent
    // of whatever the state flops held before the reset took effect.
    assign load_ready   = rstn & ready;
    assign frame        = ~rstn | in_shift;
    assign done         = rstn & done_q;
    assign serial_out   = (~rstn | in_shift) ? msb   : IDLE_LEVEL;
    assign serial_out_n = (~rstn | in_shift) ? msb_n : ~IDLE_LEVEL;

endmodule

// File: tb/tb_nc_reset_serializer.sv
// Self-checking bench for nc_reset_serializer: directed and random stimulus
// compared each cycle against a bit-queue model of the serial line.
module tb_nc_reset_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] reset_word;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         serial_out;
    logic         serial_out_n;
    logic         frame;
    logic         done;

    int errors = 0;
    int checks = 0;

    // Model: bits still to appear on the line (front = current bit).
    bit mq[$];
    bit mdone;
    bit macc;

    always #10 clk = ~clk;

    nc_reset_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .reset_word   (reset_word),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_out_n (serial_out_n),
        .frame        (frame),
        .done         (done)
    );

    task automatic chk(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, req);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) mq.push_back(w[i]);
    endtask

    task automatic model_reset(input logic [W-1:0] w);
        mq.delete();
        push_word(w);
        mdone = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic eso, efr, erdy, edn;
        if (!rstn) begin
            model_reset(reset_word);
            eso  = reset_word[W-1];
            efr  = 1'b1;
            erdy = 1'b0;
            edn  = 1'b0;
        end else begin
            eso  = (mq.size() != 0) ? mq[0] : 1'b1;
            efr  = (mq.size() != 0);
            erdy = (mq.size() <= 1);
            edn  = mdone;
        end
        chk({tag, "/serial_out"},   serial_out,   eso);
        chk({tag, "/serial_out_n"}, serial_out_n, ~eso);
        chk({tag, "/frame"},        frame,        efr);
        chk({tag, "/load_ready"},   load_ready,   erdy);
        chk({tag, "/done"},         done,         edn);
    endtask

    task automatic model_edge();
        bit rdy, nd, tmp;
        macc = 1'b0;
        if (!rstn) begin
            model_reset(reset_word);
        end else begin
            rdy  = (mq.size() <= 1);
            macc = load_valid && rdy;
            nd   = 1'b0;
            if (mq.size() != 0) begin
                tmp = mq.pop_front();
                if (mq.size() == 0) nd = 1'b1;
            end
            if (macc) push_word(load_data);
            mdone = nd;
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic do_cycle(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_accept(input string tag, input int max);
        macc = 1'b0;
        for (int i = 0; i < max; i++) begin
            do_cycle(tag);
            if (macc) break;
        end
        chk({tag, "/accepted"}, macc, 1'b1);
    endtask

    initial begin
        rstn       = 1'b1;
        reset_word = 8'hA5;
        load_valid = 1'b0;
        load_data  = '0;
        mdone      = 1'b0;
        macc       = 1'b0;

        // Reset with no clock edge: outputs track reset_word asynchronously.
        #1 rstn = 1'b0;
        #1 check_all("rst");
        reset_word = 8'h00;
        #1 check_all("async00");
        reset_word = 8'h80;
        #1 check_all("async80");
        reset_word = 8'h00;
        #1 check_all("async00b");
        reset_word = 8'hA5;
        #1 check_all("rstA5");
        @(negedge clk);
        do_cycle("rst_hold");

        // Reset word A5 goes out first, then done, then idle.
        rstn = 1'b1;
        repeat (12) do_cycle("a5");

        // Idle accept of 01.
        load_valid = 1'b1;
        load_data  = 8'h01;
        wait_accept("ld01", 1);
        load_valid = 1'b0;
        repeat (10) do_cycle("f01");

        // Back-to-back A5, 3C, C3 with valid held high.
        rstn       = 1'b0;
        reset_word = 8'hA5;
        load_valid = 1'b1;
        load_data  = 8'h3C;
        do_cycle("b2b_rst");
        rstn = 1'b1;
        wait_accept("b2b_3c", 12);
        load_data = 8'hC3;
        wait_accept("b2b_c3", 12);
        load_valid = 1'b0;
        repeat (11) do_cycle("b2b_tail");

        // Reset asserted in the middle of frame 3C.
        load_valid = 1'b1;
        load_data  = 8'h3C;
        wait_accept("mf_ld", 2);
        load_valid = 1'b0;
        repeat (4) do_cycle("mf_bits");
        #1 check_all("mf_pre");
        #1 rstn = 1'b0;
        reset_word = 8'hF0;
        #1 check_all("mf_rst");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        do_cycle("mf_hold");
        rstn = 1'b1;
        repeat (12) do_cycle("f0");

        // Valid raised mid-frame with data changing every cycle.
        load_valid = 1'b1;
        load_data  = 8'h5A;
        wait_accept("ch_ld", 2);
        macc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            load_data = 8'($urandom);
            do_cycle("ch");
            if (macc) break;
        end
        chk("ch/accepted", macc, 1'b1);
        load_valid = 1'b0;
        repeat (10) do_cycle("ch_tail");

        // Random reset words and random, rule-abiding load traffic.
        for (int r = 0; r < 3; r++) begin
            rstn       = 1'b0;
            reset_word = 8'($urandom);
            load_valid = 1'b0;
            do_cycle("rnd_rst");
            rstn = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (!load_valid && ($urandom_range(0, 2) == 0)) begin
                    load_valid = 1'b1;
                    load_data  = 8'($urandom);
                end
                do_cycle("rnd");
                if (macc) load_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
